reg_file_ctrl: RTL and testbench

//  Sequences and shares the single write port of the 32x32 register file.

---
 rtl/reg_file_ctrl_pkg.sv | 15 +
 rtl/reg_file_ctrl_if.sv | 25 ++
 rtl/reg_file_ctrl_rr_arbiter.sv | 14 +
 rtl/reg_file_ctrl.sv | 80 ++++++++
 tb/tb_reg_file_ctrl.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/reg_file_ctrl_pkg.sv
// reg_file_pkg: shared widths, FSM state encoding, requester indices and round-robin pointer helper
package reg_file_pkg;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  localparam int NUM_WB = 3;
  localparam int REG_AW = 5;
  localparam int WB_PW = $clog2(NUM_WB);
  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_MD = 2;
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
  function automatic logic [WB_PW-1:0] wb_add(input logic [WB_PW-1:0] p, input int k);
    return WB_PW'((int'(p) + k) % NUM_WB);
  endfunction
endpackage

// File: rtl/reg_file_ctrl_if.sv
// reg_file_ctrl_if: writeback handshake, decode issue/stall and reg_file write-port bundle
interface reg_file_ctrl_if;
  import reg_file_pkg::*;
  logic [NUM_WB-1:0] wb_valid_in;
  logic [REG_AW*NUM_WB-1:0] wb_rd_in;
  logic [XLEN*NUM_WB-1:0] wb_data_in;
  logic [NUM_WB-1:0] wb_ready_out;
  logic issue_valid_in;
  logic [REG_AW-1:0] issue_rd_in;
  logic [REG_AW-1:0] rs1_adder_in;
  logic [REG_AW-1:0] rs2_adder_in;
  logic stall_out;
  logic wr_en_out;
  logic [REG_AW-1:0] rd_adder_out;
  logic [XLEN-1:0] rd_data_out;
  logic init_done_out;
  modport master (
    output wb_valid_in, wb_rd_in, wb_data_in, issue_valid_in, issue_rd_in, rs1_adder_in, rs2_adder_in,
    input wb_ready_out, stall_out, wr_en_out, rd_adder_out, rd_data_out, init_done_out
  );
  modport slave (
    input wb_valid_in, wb_rd_in, wb_data_in, issue_valid_in, issue_rd_in, rs1_adder_in, rs2_adder_in,
    output wb_ready_out, stall_out, wr_en_out, rd_adder_out, rd_data_out, init_done_out
  );
endinterface

// File: rtl/reg_file_ctrl_rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin grant, search starts at ptr_i
module rr_arbiter
  import reg_file_pkg::*;
(
  input  logic [NUM_WB-1:0] req_i,
  input  logic [WB_PW-1:0]  ptr_i,
  output logic [NUM_WB-1:0] gnt_o
);
  always_comb begin
    gnt_o = '0;
    for (int k = NUM_WB - 1; k >= 0; k--)
      if (req_i[wb_add(ptr_i, k)]) gnt_o = NUM_WB'(1) << wb_add(ptr_i, k);
  end
endmodule

// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl: zero-fills x1..x31, round-robin shares the reg_file write port, busy scoreboard drives decode stall
module reg_file_ctrl
  import reg_file_pkg::*;
(
  input logic clk_in,
  input logic rst_in,
  reg_file_ctrl_if.slave bus
);
  state_e state_q, state_d;
  logic [REG_AW-1:0] cnt_q, cnt_d, rd_q, rd_d, sel_rd;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [WB_PW-1:0] ptr_q, ptr_d, sel_idx;
  logic [XLEN-1:0] data_q, data_d, sel_data;
  logic [NUM_WB-1:0] req, gnt;
  logic wr_en_q, wr_en_d, done_q, done_d, xfer, stall;
  assign req = state_q == ST_RUN ? bus.wb_valid_in : '0;
  rr_arbiter u_arb (.req_i(req), .ptr_i(ptr_q), .gnt_o(gnt));
  always_comb begin
    sel_idx = '0;
    sel_rd = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_WB; k++)
      if (gnt[k]) begin
        sel_idx = WB_PW'(k);
        sel_rd = bus.wb_rd_in[REG_AW*k +: REG_AW];
        sel_data = bus.wb_data_in[XLEN*k +: XLEN];
      end
  end
  assign xfer = |gnt;
  assign stall = ~done_q | busy_q[bus.rs1_adder_in] | busy_q[bus.rs2_adder_in]
               | (bus.issue_valid_in & busy_q[bus.issue_rd_in]);
  assign bus.wb_ready_out = gnt;
  assign bus.stall_out = stall;
  assign bus.wr_en_out = wr_en_q;
  assign bus.rd_adder_out = rd_q;
  assign bus.rd_data_out = data_q;
  assign bus.init_done_out = done_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    done_d = done_q;
    ptr_d = xfer ? wb_add(sel_idx, 1) : ptr_q;
    wr_en_d = xfer && sel_rd != '0;
    rd_d = sel_rd;
    data_d = sel_data;
    busy_d = busy_q;
    if (state_q == ST_INIT) begin
      wr_en_d = cnt_q != '0;
      rd_d = cnt_q;
      data_d = '0;
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == '0 ? ST_RUN : ST_INIT;
      done_d = cnt_q == '0;
    end
    if (xfer) busy_d[sel_rd] = 1'b0;
    if (bus.issue_valid_in && !stall) busy_d[bus.issue_rd_in] = 1'b1;
    busy_d[0] = 1'b0;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= ST_INIT;
      cnt_q <= REG_AW'(1);
      busy_q <= '0;
      ptr_q <= '0;
      wr_en_q <= 1'b0;
      rd_q <= '0;
      data_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      ptr_q <= ptr_d;
      wr_en_q <= wr_en_d;
      rd_q <= rd_d;
      data_q <= data_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb_reg_file_ctrl: directed vectors with hand-computed expectations for reg_file_ctrl
module tb_reg_file_ctrl;
  import reg_file_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  logic [XLEN-1:0] wb_dat [NUM_WB] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
  reg_file_ctrl_if bus ();
  reg_file_ctrl dut (.clk_in(clk), .rst_in(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_wb(input int i, input logic [4:0] rd, input logic [31:0] dat);
    bus.wb_rd_in[REG_AW*i +: REG_AW] = rd;
    bus.wb_data_in[XLEN*i +: XLEN] = dat;
  endtask
  task automatic init_seq();
    for (int i = 1; i <= 31; i++) begin
      cyc();
      chk("init_wr_en", 32'(bus.wr_en_out), 1);
      chk("init_rd", 32'(bus.rd_adder_out), i);
      chk("init_data", bus.rd_data_out, 0);
      chk("init_stall", 32'(bus.stall_out), 1);
      chk("init_ready", 32'(bus.wb_ready_out), 0);
    end
    cyc();
    chk("done_rise", 32'(bus.init_done_out), 1);
    chk("done_wr_en", 32'(bus.wr_en_out), 0);
  endtask
  initial begin
    rst = 1'b0;
    bus.issue_valid_in = 1'b0;
    bus.issue_rd_in = '0;
    bus.rs1_adder_in = '0;
    bus.rs2_adder_in = '0;
    bus.wb_valid_in = 3'b111;
    for (int i = 0; i < NUM_WB; i++) set_wb(i, 5'(5 + i), wb_dat[i]);
    cyc();
    cyc();
    chk("rst_wr_en", 32'(bus.wr_en_out), 0);
    chk("rst_rd", 32'(bus.rd_adder_out), 0);
    chk("rst_data", bus.rd_data_out, 0);
    chk("rst_done", 32'(bus.init_done_out), 0);
    chk("rst_stall", 32'(bus.stall_out), 1);
    chk("rst_ready", 32'(bus.wb_ready_out), 0);
    rst = 1'b1;
    init_seq();
    chk("run_stall", 32'(bus.stall_out), 0);
    for (int j = 0; j < 4; j++) begin
      chk("rr_grant", 32'(bus.wb_ready_out), 1 << (j % 3));
      cyc();
      chk("rr_wr_en", 32'(bus.wr_en_out), 1);
      chk("rr_rd", 32'(bus.rd_adder_out), 5 + (j % 3));
      chk("rr_data", bus.rd_data_out, wb_dat[j % 3]);
    end
    bus.wb_valid_in = '0;
    #1;
    chk("idle_ready", 32'(bus.wb_ready_out), 0);
    bus.issue_valid_in = 1'b1;
    bus.issue_rd_in = 5'd9;
    #1;
    chk("iss9_stall", 32'(bus.stall_out), 0);
    cyc();
    bus.issue_valid_in = 1'b0;
    bus.rs1_adder_in = 5'd9;
    #1;
    chk("raw9_stall", 32'(bus.stall_out), 1);
    chk("idle_wr_en", 32'(bus.wr_en_out), 0);
    cyc();
    chk("raw9_hold", 32'(bus.stall_out), 1);
    set_wb(WB_LSU, 5'd9, 32'hDEAD_BEEF);
    bus.wb_valid_in = 3'b010;
    #1;
    chk("lsu9_ready", 32'(bus.wb_ready_out), 3'b010);
    chk("lsu9_stall", 32'(bus.stall_out), 1);
    cyc();
    bus.wb_valid_in = '0;
    #1;
    chk("clr9_stall", 32'(bus.stall_out), 0);
    chk("lsu9_wr_en", 32'(bus.wr_en_out), 1);
    chk("lsu9_rd", 32'(bus.rd_adder_out), 9);
    chk("lsu9_data", bus.rd_data_out, 32'hDEAD_BEEF);
    bus.rs1_adder_in = '0;
    bus.issue_valid_in = 1'b1;
    bus.issue_rd_in = '0;
    set_wb(WB_LSU, 5'd0, 32'h1234_5678);
    bus.wb_valid_in = 3'b010;
    #1;
    chk("x0_stall", 32'(bus.stall_out), 0);
    chk("x0_ready", 32'(bus.wb_ready_out), 3'b010);
    cyc();
    bus.issue_valid_in = 1'b0;
    bus.wb_valid_in = '0;
    #1;
    chk("x0_wr_en", 32'(bus.wr_en_out), 0);
    chk("x0_after", 32'(bus.stall_out), 0);
    bus.issue_valid_in = 1'b1;
    bus.issue_rd_in = 5'd12;
    set_wb(WB_ALU, 5'd12, 32'h0000_1212);
    bus.wb_valid_in = 3'b001;
    #1;
    chk("sc12_stall", 32'(bus.stall_out), 0);
    chk("sc12_ready", 32'(bus.wb_ready_out), 3'b001);
    cyc();
    bus.issue_valid_in = 1'b0;
    bus.wb_valid_in = '0;
    bus.rs2_adder_in = 5'd12;
    #1;
    chk("sc12_busy", 32'(bus.stall_out), 1);
    chk("sc12_wr_en", 32'(bus.wr_en_out), 1);
    chk("sc12_rd", 32'(bus.rd_adder_out), 12);
    bus.rs2_adder_in = '0;
    bus.issue_valid_in = 1'b1;
    bus.issue_rd_in = 5'd3;
    #1;
    chk("iss3_stall", 32'(bus.stall_out), 0);
    cyc();
    bus.issue_valid_in = 1'b0;
    bus.rs1_adder_in = 5'd3;
    for (int i = 0; i < NUM_WB; i++) set_wb(i, 5'(20 + i), wb_dat[i]);
    bus.wb_valid_in = 3'b111;
    #1;
    chk("b3_stall", 32'(bus.stall_out), 1);
    chk("pre_rst_ready", 32'(bus.wb_ready_out), 3'b010);
    rst = 1'b0;
    cyc();
    chk("mid_rst_ready", 32'(bus.wb_ready_out), 0);
    chk("mid_rst_wr_en", 32'(bus.wr_en_out), 0);
    chk("mid_rst_done", 32'(bus.init_done_out), 0);
    chk("mid_rst_stall", 32'(bus.stall_out), 1);
    rst = 1'b1;
    init_seq();
    bus.rs2_adder_in = 5'd12;
    #1;
    chk("post_busy_clr", 32'(bus.stall_out), 0);
    chk("post_ptr0", 32'(bus.wb_ready_out), 3'b001);
    bus.wb_valid_in = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
